// File: rtl/chacha_block_function.sv
// rtl/chacha_block_function.sv - ChaCha20 block function, free-running keystream generator
// Emits one 512-bit keystream block every ROUNDS+2 cycles with a one-cycle strobe.
module chacha_block_function #(
  parameter int          ROUNDS       = 20,
  parameter logic [31:0] COUNTER_INIT = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Key       [0:7],
  input  logic [31:0] Nonce     [2:0],
  input  logic [31:0] Constant  [3:0],
  output logic [31:0] MatrixOut [3:0][3:0],
  output logic        serial_enable
);

  typedef enum logic [1:0] {LOAD, ROUND, FINAL} state_t;

  state_t      state;
  logic [31:0] counter;
  logic [7:0]  rnd;
  logic        blockready;
  logic [31:0] chachatoQround [0:3][0:3];
  logic [31:0] init_s [0:15];
  logic [31:0] w      [0:15];
  logic [31:0] w_next [0:15];
  logic [127:0] q;
  logic [3:0]  ia, ib, ic, id;

  assign serial_enable = blockready;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_in, b_in, c_in, d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      chachatoQround[0][c] = Constant[c];
      chachatoQround[1][c] = Key[c];
      chachatoQround[2][c] = Key[4 + c];
    end
    chachatoQround[3][0] = counter;
    chachatoQround[3][1] = Nonce[0];
    chachatoQround[3][2] = Nonce[1];
    chachatoQround[3][3] = Nonce[2];
  end

  // rnd[0]=0 selects column round; rnd[0]=1 rotates rows 1..3 into diagonals
  always_comb begin
    w_next = w;
    q  = '0;
    ia = '0; ib = '0; ic = '0; id = '0;
    for (int i = 0; i < 4; i++) begin
      ia = {2'd0, 2'(i)};
      ib = {2'd1, 2'(i) + {1'b0, rnd[0]}};
      ic = {2'd2, 2'(i) + {rnd[0], 1'b0}};
      id = {2'd3, 2'(i) + {2{rnd[0]}}};
      q  = qr(w[ia], w[ib], w[ic], w[id]);
      w_next[ia] = q[127:96];
      w_next[ib] = q[95:64];
      w_next[ic] = q[63:32];
      w_next[id] = q[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      counter    <= COUNTER_INIT;
      rnd        <= '0;
      blockready <= 1'b0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          MatrixOut[r][c] <= '0;
    end else begin
      blockready <= 1'b0;
      case (state)
        LOAD: begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
              init_s[4*r + c] <= chachatoQround[r][c];
              w[4*r + c]      <= chachatoQround[r][c];
            end
          rnd   <= '0;
          state <= ROUND;
        end
        ROUND: begin
          for (int i = 0; i < 16; i++)
            w[i] <= w_next[i];
          rnd <= rnd + 8'd1;
          if (rnd == 8'(ROUNDS - 1))
            state <= FINAL;
        end
        FINAL: begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              MatrixOut[r][c] <= w[4*r + c] + init_s[4*r + c];
          blockready <= 1'b1;
          counter    <= counter + 32'd1;
          state      <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_function.sv
// tb/tb_chacha_block_function.sv - scoreboard bench for chacha_block_function
// Expected blocks are queued at each LOAD and compared when serial_enable strobes.
module tb_chacha_block_function;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] key  [0:7];
  logic [31:0] nonce[2:0];
  logic [31:0] cst  [3:0];
  logic [31:0] mat  [3:0][3:0];
  logic        serial_enable;

  chacha_block_function dut (
    .clk          (clk),
    .rst          (rst),
    .Key          (key),
    .Nonce        (nonce),
    .Constant     (cst),
    .MatrixOut    (mat),
    .serial_enable(serial_enable)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] blk;
    logic [31:0]  nctr;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          nxt   = 22;
  logic [31:0] exp_ctr;
  logic [31:0] x [0:15];
  logic [31:0] s [0:15];
  logic [31:0] rfc [0:15] = '{
    32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
    32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
    32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
    32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%08h want=%08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  task automatic qrm(input int a, input int b, input int c, input int d);
    x[a] = x[a] + x[b]; x[d] = x[d] ^ x[a]; x[d] = rl(x[d], 16);
    x[c] = x[c] + x[d]; x[b] = x[b] ^ x[c]; x[b] = rl(x[b], 12);
    x[a] = x[a] + x[b]; x[d] = x[d] ^ x[a]; x[d] = rl(x[d], 8);
    x[c] = x[c] + x[d]; x[b] = x[b] ^ x[c]; x[b] = rl(x[b], 7);
  endtask

  task automatic push_block(input bit use_rfc);
    exp_t e;
    check("load_ctr", dut.chachatoQround[3][0], exp_ctr);
    for (int k = 0; k < 4; k++) x[k] = cst[k];
    for (int k = 0; k < 8; k++) x[4 + k] = key[k];
    x[12] = exp_ctr;
    x[13] = nonce[0]; x[14] = nonce[1]; x[15] = nonce[2];
    for (int k = 0; k < 16; k++) s[k] = x[k];
    for (int dr = 0; dr < 10; dr++) begin
      qrm(0, 4, 8, 12); qrm(1, 5, 9, 13); qrm(2, 6, 10, 14); qrm(3, 7, 11, 15);
      qrm(0, 5, 10, 15); qrm(1, 6, 11, 12); qrm(2, 7, 8, 13); qrm(3, 4, 9, 14);
    end
    for (int k = 0; k < 16; k++)
      e.blk[32*k +: 32] = use_rfc ? rfc[k] : x[k] + s[k];
    e.nctr = exp_ctr + 32'd1;
    sb.push_back(e);
    exp_ctr = exp_ctr + 32'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("rst_mat%0d%0d", r, c), mat[r][c], 32'h0);
    check("rst_strobe", {31'b0, serial_enable}, 32'h0);
    check("rst_ctr", dut.chachatoQround[3][0], 32'h1);
    sb.delete();
    exp_ctr = 32'd1;
    rst = 1'b0;
  endtask

  task automatic set_rfc_inputs();
    cst[0] = 32'h61707865; cst[1] = 32'h3320646e;
    cst[2] = 32'h79622d32; cst[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++)
      key[i] = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
    nonce[0] = 32'h09000000; nonce[1] = 32'h4a000000; nonce[2] = 32'h0;
  endtask

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      nxt = 22;
    end else if (serial_enable) begin
      check("strobe_cyc", cyc, nxt);
      nxt = nxt + 22;
      if (sb.size() == 0) begin
        check("strobe_unexpected", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        for (int k = 0; k < 16; k++)
          check($sformatf("blk_w%0d", k), mat[k / 4][k % 4], e.blk[32*k +: 32]);
        check("next_ctr", dut.chachatoQround[3][0], e.nctr);
      end
    end
  end

  initial begin
    rst = 1'b1;
    exp_ctr = 32'd1;
    set_rfc_inputs();
    @(negedge clk);
    do_reset();

    // RFC vector, then counters 2 and 3 with the same inputs
    push_block(1'b1);
    repeat (22) @(negedge clk);
    repeat (2) begin
      push_block(1'b0);
      repeat (22) @(negedge clk);
    end

    // abort around round 10, then the RFC block must reappear
    push_block(1'b0);
    repeat (11) @(negedge clk);
    do_reset();
    push_block(1'b1);
    repeat (22) @(negedge clk);

    // all-zero key and nonce with counter 1
    do_reset();
    for (int i = 0; i < 8; i++) key[i] = 32'h0;
    nonce[0] = 32'h0; nonce[1] = 32'h0; nonce[2] = 32'h0;
    push_block(1'b0);
    repeat (22) @(negedge clk);
    check("zero_w0", mat[0][0], 32'hbee7079f);
    check("zero_w1", mat[0][1], 32'h7a385155);

    // key changes mid-block must only affect the following block
    set_rfc_inputs();
    push_block(1'b0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) key[i] = $urandom;
    repeat (17) @(negedge clk);
    push_block(1'b0);
    repeat (22) @(negedge clk);

    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 8; i++) key[i] = $urandom;
      for (int i = 0; i < 4; i++) cst[i] = $urandom;
      for (int i = 0; i < 3; i++) nonce[i] = $urandom;
      push_block(1'b0);
      repeat (22) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
